// File: rtl/tetris_pkg.sv
// Shared types for the tile mover: board size, coordinates, tile/command
// encodings, controller states and the command-to-delta helper.
package tetris;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int COORD_W = 5;

   typedef enum logic [2:0] {eNon, eI, eO, eT, eS, eZ, eJ, eL} tile_type_e;
   typedef enum logic [1:0] {eLeft, eRight, eRotate, eDown} move_cmd_e;

   typedef struct packed {
      logic [COORD_W-1:0] x_m;
      logic [COORD_W-1:0] y_m;
   } point_t;

   typedef struct packed {
      tile_type_e tile_m;
      logic [1:0] angle_m;
   } shape_info_t;

   // One bit wider than a coordinate so a step off either edge stays representable.
   typedef logic signed [COORD_W:0] coord_s_t;

   typedef struct packed {
      coord_s_t dx_m;
      coord_s_t dy_m;
   } delta_t;

   typedef enum logic [2:0] {IDLE, SPAWN, SHAPE_WAIT, READY, CHECK, REVERT} ctrl_state_e;

   function automatic delta_t cmd_delta(input move_cmd_e cmd);
      delta_t d;
      d = '0;
      case (cmd)
         eLeft:   d.dx_m = coord_s_t'(-1);
         eRight:  d.dx_m = coord_s_t'(1);
         eDown:   d.dy_m = coord_s_t'(1);
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/tile_bounds_check.sv
// Combinational legality test: does the bounding box, shifted by delta,
// still lie inside the board?
module tile_bounds_check
   import tetris::*;
(
   input  point_t min_pos_i,
   input  point_t max_pos_i,
   input  delta_t delta_i,
   output logic   legal_o
);

   coord_s_t min_x, max_x, min_y, max_y;

   always_comb begin
      min_x   = coord_s_t'({1'b0, min_pos_i.x_m}) + delta_i.dx_m;
      max_x   = coord_s_t'({1'b0, max_pos_i.x_m}) + delta_i.dx_m;
      min_y   = coord_s_t'({1'b0, min_pos_i.y_m}) + delta_i.dy_m;
      max_y   = coord_s_t'({1'b0, max_pos_i.y_m}) + delta_i.dy_m;
      legal_o = (min_x >= 0) && (max_x <= coord_s_t'(BOARD_W - 1)) &&
                (min_y >= 0) && (max_y <= coord_s_t'(BOARD_H - 1));
   end

endmodule

// File: rtl/tile_move_controller.sv
// Tile movement controller: spawns tiles, applies user moves/rotations with
// bounds checking, reverts illegal rotations. Define TILE_GRAVITY_EN for auto-drop.
module tile_move_controller
   import tetris::*;
#(
   parameter int GRAVITY_PERIOD = 25000000,
   parameter int SPAWN_X        = 4,
   parameter int SPAWN_Y        = 0
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       spawn_v_i,
   input  tile_type_e spawn_type_i,
   input  logic       cmd_v_i,
   input  move_cmd_e  cmd_i,
   output logic       cmd_ready_o,
   input  point_t     pos_i,
   input  point_t     min_pos_i,
   input  point_t     max_pos_i,
   output tile_type_e tile_type_o,
   output logic [1:0] tile_angle_o,
   output logic       tile_type_v_o,
   output point_t     new_pos_o,
   output logic       pos_v_o,
   output logic       landed_o
);

   ctrl_state_e state_q, state_d;
   shape_info_t shape_q, shape_d;
   logic [1:0]  prev_angle_q, prev_angle_d;
   move_cmd_e   cmd_q, cmd_d;
   delta_t      delta_q, delta_d;
   logic        spawn_pos_q, spawn_pos_d;
   logic        wait_last_q, wait_last_d;
   logic        ret_check_q, ret_check_d;
   logic        move_legal;
   logic        gravity_due;

   tile_bounds_check u_bounds (
      .min_pos_i (min_pos_i),
      .max_pos_i (max_pos_i),
      .delta_i   (delta_q),
      .legal_o   (move_legal)
   );

   assign tile_type_o = shape_q.tile_m;

   // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d       = state_q;
      shape_d       = shape_q;
      prev_angle_d  = prev_angle_q;
      cmd_d         = cmd_q;
      delta_d       = delta_q;
      spawn_pos_d   = 1'b0;
      wait_last_d   = wait_last_q;
      ret_check_d   = ret_check_q;
      cmd_ready_o   = 1'b0;
      tile_type_v_o = 1'b0;
      tile_angle_o  = shape_q.angle_m;
      pos_v_o       = 1'b0;
      new_pos_o     = '0;
      landed_o      = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (spawn_v_i) begin
               shape_d = '{tile_m: spawn_type_i, angle_m: 2'd0};
               state_d = SPAWN;
            end
         end
         SPAWN: begin
            if (!spawn_pos_q) begin
               tile_type_v_o = 1'b1;
               spawn_pos_d   = 1'b1;
            end else begin
               // The position write doubles as the first shape-settle cycle.
               pos_v_o        = 1'b1;
               new_pos_o.x_m  = COORD_W'(SPAWN_X);
               new_pos_o.y_m  = COORD_W'(SPAWN_Y);
               wait_last_d    = 1'b1;
               ret_check_d    = 1'b0;
               state_d        = SHAPE_WAIT;
            end
         end
         SHAPE_WAIT: begin
            wait_last_d = 1'b1;
            if (wait_last_q) state_d = ret_check_q ? CHECK : READY;
         end
         READY: begin
            cmd_ready_o = 1'b1;
            if (spawn_v_i) begin
               shape_d = '{tile_m: spawn_type_i, angle_m: 2'd0};
               state_d = SPAWN;
            end else if (gravity_due) begin
               cmd_d   = eDown;
               delta_d = cmd_delta(eDown);
               state_d = CHECK;
            end else if (cmd_v_i) begin
               cmd_d   = cmd_i;
               delta_d = cmd_delta(cmd_i);
               if (cmd_i == eRotate) begin
                  tile_type_v_o   = 1'b1;
                  tile_angle_o    = shape_q.angle_m + 2'd1;
                  shape_d.angle_m = shape_q.angle_m + 2'd1;
                  prev_angle_d    = shape_q.angle_m;
                  wait_last_d     = 1'b0;
                  ret_check_d     = 1'b1;
                  state_d         = SHAPE_WAIT;
               end else begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            state_d = READY;
            if (cmd_q == eRotate) begin
               if (!move_legal) begin
                  shape_d.angle_m = prev_angle_q;
                  state_d         = REVERT;
               end
            end else if (move_legal) begin
               pos_v_o       = 1'b1;
               new_pos_o.x_m = pos_i.x_m + delta_q.dx_m[COORD_W-1:0];
               new_pos_o.y_m = pos_i.y_m + delta_q.dy_m[COORD_W-1:0];
            end else if (cmd_q == eDown) begin
               landed_o = 1'b1;
               state_d  = IDLE;
            end
         end
         REVERT: begin
            tile_type_v_o = 1'b1;
            wait_last_d   = 1'b0;
            ret_check_d   = 1'b0;
            state_d       = SHAPE_WAIT;
         end
         default: state_d = IDLE;
      endcase

      // A cycle with reset asserted must not leak any strobe or acceptance.
      if (reset_i) begin
         cmd_ready_o   = 1'b0;
         tile_type_v_o = 1'b0;
         tile_angle_o  = shape_q.angle_m;
         pos_v_o       = 1'b0;
         new_pos_o     = '0;
         landed_o      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         shape_q      <= '{tile_m: eNon, angle_m: 2'd0};
         prev_angle_q <= 2'd0;
         cmd_q        <= eLeft;
         delta_q      <= '0;
         spawn_pos_q  <= 1'b0;
         wait_last_q  <= 1'b0;
         ret_check_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shape_q      <= shape_d;
         prev_angle_q <= prev_angle_d;
         cmd_q        <= cmd_d;
         delta_q      <= delta_d;
         spawn_pos_q  <= spawn_pos_d;
         wait_last_q  <= wait_last_d;
         ret_check_q  <= ret_check_d;
      end
   end

`ifdef TILE_GRAVITY_EN
   localparam int GRAV_W = (GRAVITY_PERIOD > 1) ? $clog2(GRAVITY_PERIOD) : 1;

   logic [GRAV_W-1:0] grav_cnt_q, grav_cnt_d;
   logic              grav_pend_q, grav_pend_d;
   logic              grav_wrap, grav_take;

   always_comb begin
      grav_cnt_d  = grav_cnt_q;
      grav_pend_d = grav_pend_q;
      grav_wrap   = 1'b0;
      grav_take   = (state_q == READY) && !spawn_v_i && grav_pend_q;
      if (state_q == IDLE) begin
         grav_cnt_d  = '0;
         grav_pend_d = 1'b0;
      end else begin
         if (grav_cnt_q == GRAV_W'(GRAVITY_PERIOD - 1)) begin
            grav_cnt_d = '0;
            grav_wrap  = 1'b1;
         end else begin
            grav_cnt_d = grav_cnt_q + GRAV_W'(1);
         end
         grav_pend_d = (grav_pend_q && !grav_take) || grav_wrap;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         grav_cnt_q  <= '0;
         grav_pend_q <= 1'b0;
      end else begin
         grav_cnt_q  <= grav_cnt_d;
         grav_pend_q <= grav_pend_d;
      end
   end

   assign gravity_due = grav_pend_q;
`else
   logic unused_gravity_period;
   assign unused_gravity_period = (GRAVITY_PERIOD > 0);
   assign gravity_due           = 1'b0;
`endif

endmodule

// File: doc/tile_move_controller.md
TILE_MOVE_CONTROLLER -- requirements
Module: tile_move_controller

Interface
REQ-001 SHALL have parameter GRAVITY_PERIOD, default 25000000, clock cycles between gravity down-steps (used only with TILE_GRAVITY_EN).
REQ-002 SHALL have parameter SPAWN_X, default 4, spawn x coordinate; SPAWN_Y, default 0, spawn y coordinate.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spawn_v_i  input  1  request a new tile; spawn_type_i  input  tile_type_e  its type.
REQ-006 SHALL have port cmd_v_i  input  1  user command valid; cmd_i  input  move_cmd_e  eLeft/eRight/eRotate/eDown.
REQ-007 SHALL have port cmd_ready_o  output  1  high when a command or spawn is accepted this cycle.
REQ-008 SHALL have port pos_i, min_pos_i, max_pos_i  input  point_t  current anchor and bounding box from tile memory.
REQ-009 SHALL have port tile_type_o  output  tile_type_e; tile_angle_o  output  2  angle; tile_type_v_o  output  1  write strobe.
REQ-010 SHALL have port new_pos_o  output  point_t; pos_v_o  output  1  position write strobe.
REQ-011 SHALL have port landed_o  output  1  one-cycle pulse when a down-step is blocked by the floor.

Function
REQ-012 SHALL implement FSM states IDLE, SPAWN, SHAPE_WAIT, READY, CHECK, REVERT.
REQ-013 IDLE: cmd_ready_o=1; spawn_v_i accepted -> SPAWN; commands ignored (no tile).
REQ-014 SPAWN: tile_type_v_o=1, tile_angle_o=0 for one cycle; next cycle pos_v_o=1 with new_pos_o=(SPAWN_X,SPAWN_Y); -> SHAPE_WAIT.
REQ-015 tile_type_v_o and pos_v_o SHALL never be high in the same cycle.
REQ-016 SHAPE_WAIT SHALL last exactly 2 cycles after any type/angle write (ROM read + shape register) before bounds are used.
REQ-017 READY: cmd_ready_o=1; accepted eLeft/eRight/eDown -> CHECK with delta (-1,0)/(+1,0)/(0,+1); eRotate -> write angle+1 mod 4 (wraps 3->0), SHAPE_WAIT, then CHECK with delta (0,0); spawn_v_i in READY -> SPAWN.
REQ-018 CHECK: legal iff min_pos_i.x_m+dx>=0, max_pos_i.x_m+dx<=BOARD_W-1, min_pos_i.y_m+dy>=0, max_pos_i.y_m+dy<=BOARD_H-1; arithmetic signed, one bit wider than point_t field.
REQ-019 CHECK legal move: pos_v_o=1, new_pos_o=pos_i+delta, -> READY; legal rotate: no write, -> READY.
REQ-020 CHECK illegal rotate -> REVERT: tile_type_v_o=1 with previous angle, SHAPE_WAIT, -> READY.
REQ-021 CHECK illegal eDown: landed_o=1 one cycle, -> IDLE; illegal eLeft/eRight: no write, -> READY.
REQ-022 cmd_ready_o SHALL be 0 in SPAWN, SHAPE_WAIT, CHECK, REVERT; commands then are dropped, not queued.
REQ-023 Simultaneous spawn_v_i and cmd_v_i in READY: spawn wins, command dropped.

Reset
REQ-024 reset_i SHALL force state IDLE, tile_type_o=eNon, tile_angle_o=0, all strobes 0, landed_o=0, new_pos_o=0, gravity counter 0, cmd_ready_o=1 next cycle.
REQ-025 reset_i mid-operation (any state) SHALL abort without emitting a strobe that cycle.

Configuration
REQ-026 With TILE_GRAVITY_EN defined, an internal counter SHALL wrap at GRAVITY_PERIOD-1 and raise a pending eDown, taken in READY with priority below spawn and above cmd_v_i (user command dropped that cycle); counter runs only outside IDLE.
REQ-027 Without TILE_GRAVITY_EN, no counter SHALL exist; down moves come only from cmd_i=eDown.

Structure
REQ-028 move_cmd_e, BOARD_W (10), BOARD_H (20) SHALL live in package tetris alongside point_t, tile_type_e, shape_info_t.
REQ-029 Bounds checking SHALL be a combinational sub-module tile_bounds_check (box, delta -> legal).

Verification
REQ-030 Spawn eI -> tile_type_v_o pulse angle 0, next cycle pos_v_o with (4,0), cmd_ready_o low 3 cycles then high.
REQ-031 Box x 0..3, eLeft -> no pos_v_o, stays READY; eRight -> new_pos_o.x_m=pos_i.x_m+1.
REQ-032 Box max y 19, eDown -> landed_o one pulse, state IDLE, no pos_v_o.
REQ-033 Angle 3 rotate at x 8..9 with rotated box x 8..11 -> angle 0 written, then REVERT rewrites 3, no pos_v_o.
REQ-034 Gravity enabled, GRAVITY_PERIOD=8, no commands -> pos_v_o y+1 every 8+ cycles until landed_o.
REQ-035 reset_i asserted in SHAPE_WAIT -> next cycle IDLE, tile_type_o=eNon, all strobes 0.
